// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: lock-detector state encoding and the default phase-error width.
package adpll_pkg;

    localparam int ADPLL_ERR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } lock_state_t;

endpackage

// File: rtl/adpll_abs_sat.sv
// Saturating absolute value of a two's-complement word; the most-negative input maps to the
// largest positive value so the result always fits in W unsigned bits below 2^(W-1).
module adpll_abs_sat #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] val_i,
    output logic        [W-1:0] abs_o
);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    always_comb begin
        abs_o = $unsigned(val_i);
        if ($unsigned(val_i) == MOST_NEG) begin
            abs_o = MOST_POS;
        end else if (val_i[W-1]) begin
            abs_o = $unsigned(-val_i);
        end
    end

endmodule

// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: hysteretic acquire/release FSM sampled on ref_clk_i rising edges.
// Optional peak-error tracking while locked is enabled by defining LOCK_PEAK_EN.
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int ERR_WIDTH     = ADPLL_ERR_WIDTH,
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOCK_COUNT    = 64,
    parameter int UNLOCK_COUNT  = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                        fpga_clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        ref_clk_i,
    input  logic signed [ERR_WIDTH-1:0] error_i,
    output logic                        locked_o,
    output logic [1:0]                  lock_state_o,
    output logic                        lost_lock_o,
    output logic [ERR_WIDTH-1:0]        max_abs_error_o
);

    localparam logic [ERR_WIDTH-1:0] LOCK_TH   = ERR_WIDTH'(LOCK_THRESH);
    localparam logic [ERR_WIDTH-1:0] UNLOCK_TH = ERR_WIDTH'(UNLOCK_THRESH);
    localparam logic [CNT_WIDTH:0]   ACQ_END   = (CNT_WIDTH+1)'(LOCK_COUNT);
    localparam logic [CNT_WIDTH:0]   REL_END   = (CNT_WIDTH+1)'(UNLOCK_COUNT);

    lock_state_t           state_q;
    logic                  ref_q;
    logic                  locked_q;
    logic                  lost_q;
    logic [CNT_WIDTH-1:0]  acq_cnt_q;
    logic [CNT_WIDTH-1:0]  rel_cnt_q;
    logic [ERR_WIDTH-1:0]  abs_err;
    logic                  strobe;
    logic                  good;
    logic                  bad;
    logic [CNT_WIDTH:0]    acq_inc;
    logic [CNT_WIDTH:0]    rel_inc;

    adpll_abs_sat #(.W(ERR_WIDTH)) u_abs (
        .val_i (error_i),
        .abs_o (abs_err)
    );

    assign strobe  = ref_clk_i & ~ref_q;
    assign good    = (abs_err <= LOCK_TH);
    assign bad     = (abs_err > UNLOCK_TH);
    // One extra bit so the terminal compare happens before the counter could wrap.
    assign acq_inc = {1'b0, acq_cnt_q} + (CNT_WIDTH+1)'(1);
    assign rel_inc = {1'b0, rel_cnt_q} + (CNT_WIDTH+1)'(1);

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q   <= ST_UNLOCKED;
            ref_q     <= 1'b0;
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
            acq_cnt_q <= '0;
            rel_cnt_q <= '0;
        end else begin
            ref_q  <= ref_clk_i;
            lost_q <= 1'b0;
            if (!enable_i) begin
                state_q   <= ST_UNLOCKED;
                locked_q  <= 1'b0;
                acq_cnt_q <= '0;
                rel_cnt_q <= '0;
            end else if (strobe) begin
                case (state_q)
                    ST_UNLOCKED: begin
                        if (good) begin
                            if (LOCK_COUNT == 1) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q   <= ST_ACQUIRE;
                                acq_cnt_q <= CNT_WIDTH'(1);
                            end
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!good) begin
                            state_q   <= ST_UNLOCKED;
                            acq_cnt_q <= '0;
                        end else if (acq_inc == ACQ_END) begin
                            state_q   <= ST_LOCKED;
                            locked_q  <= 1'b1;
                            acq_cnt_q <= '0;
                        end else begin
                            acq_cnt_q <= acq_inc[CNT_WIDTH-1:0];
                        end
                    end
                    ST_LOCKED: begin
                        if (bad) begin
                            if (UNLOCK_COUNT == 1) begin
                                state_q  <= ST_UNLOCKED;
                                locked_q <= 1'b0;
                                lost_q   <= 1'b1;
                            end else begin
                                state_q   <= ST_HOLDOVER;
                                rel_cnt_q <= CNT_WIDTH'(1);
                            end
                        end
                    end
                    ST_HOLDOVER: begin
                        if (!bad) begin
                            state_q   <= ST_LOCKED;
                            rel_cnt_q <= '0;
                        end else if (rel_inc == REL_END) begin
                            state_q   <= ST_UNLOCKED;
                            locked_q  <= 1'b0;
                            lost_q    <= 1'b1;
                            acq_cnt_q <= '0;
                            rel_cnt_q <= '0;
                        end else begin
                            rel_cnt_q <= rel_inc[CNT_WIDTH-1:0];
                        end
                    end
                    default: begin
                        state_q  <= ST_UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LOCK_PEAK_EN
    logic [ERR_WIDTH-1:0] peak_q;
    logic                 enter_lock;

    assign enter_lock = good && (((state_q == ST_UNLOCKED) && (LOCK_COUNT == 1)) ||
                                 ((state_q == ST_ACQUIRE) && (acq_inc == ACQ_END)));

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            peak_q <= '0;
        end else if (enable_i && strobe) begin
            if (enter_lock) begin
                peak_q <= '0;
            end else if (((state_q == ST_LOCKED) || (state_q == ST_HOLDOVER)) && (abs_err > peak_q)) begin
                peak_q <= abs_err;
            end
        end
    end

    assign max_abs_error_o = peak_q;
`else
    assign max_abs_error_o = '0;
`endif

    assign locked_o     = locked_q;
    assign lock_state_o = state_q;
    assign lost_lock_o  = lost_q;

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Directed bench for adpll_lock_detect: strobe-vector table plus enable/reset corner sequences.
module tb_adpll_lock_detect;

`ifdef LOCK_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              ref_clk = 1'b0;
    logic signed [7:0] err = '0;
    logic              locked;
    logic [1:0]        state;
    logic              lost;
    logic [7:0]        peak;

    int n_checks = 0;
    int n_fail   = 0;

    adpll_lock_detect dut (
        .fpga_clk_i      (clk),
        .reset_i         (reset),
        .enable_i        (enable),
        .ref_clk_i       (ref_clk),
        .error_i         (err),
        .locked_o        (locked),
        .lock_state_o    (state),
        .lost_lock_o     (lost),
        .max_abs_error_o (peak)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] err;
        logic              en;
        int                reps;
        logic [1:0]        st;
        logic              lk;
        logic              lost;
        logic [7:0]        peak;
    } vec_t;

    vec_t vt[14];

    logic [1:0] s_state;
    logic       s_locked;
    logic       s_lost;
    logic       s_lost_next;
    logic [7:0] s_peak;

    function automatic logic [7:0] pk(input int v);
        return PEAK_ON ? 8'(v) : 8'd0;
    endfunction

    function automatic vec_t mk(input int e, input int reps, input int st, input int lk,
                                input int ls, input int p);
        vec_t v;
        v.err  = 8'(e);
        v.en   = 1'b1;
        v.reps = reps;
        v.st   = 2'(st);
        v.lk   = lk[0];
        v.lost = ls[0];
        v.peak = pk(p);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One strobe cycle followed by three idle cycles; samples taken on falling edges.
    task automatic apply(input logic signed [7:0] e, input logic en);
        @(negedge clk);
        err     = e;
        enable  = en;
        ref_clk = 1'b1;
        @(negedge clk);
        ref_clk  = 1'b0;
        s_state  = state;
        s_locked = locked;
        s_lost   = lost;
        s_peak   = peak;
        @(negedge clk);
        s_lost_next = lost;
        @(negedge clk);
    endtask

    task automatic strobes(input logic signed [7:0] e, input int n);
        for (int i = 0; i < n; i++) apply(e, 1'b1);
    endtask

    initial begin
        vt[0]  = mk(3,    1,  1, 0, 0, 0);
        vt[1]  = mk(3,    62, 1, 0, 0, 0);
        vt[2]  = mk(3,    1,  2, 1, 0, 0);
        vt[3]  = mk(9,    3,  3, 1, 0, 9);
        vt[4]  = mk(0,    1,  2, 1, 0, 9);
        vt[5]  = mk(6,    1,  2, 1, 0, 9);
        vt[6]  = mk(-20,  3,  3, 1, 0, 20);
        vt[7]  = mk(-20,  1,  0, 0, 1, 20);
        vt[8]  = mk(3,    63, 1, 0, 0, 20);
        vt[9]  = mk(6,    1,  0, 0, 0, 20);
        vt[10] = mk(3,    63, 1, 0, 0, 20);
        vt[11] = mk(3,    1,  2, 1, 0, 0);
        vt[12] = mk(-128, 1,  3, 1, 0, 127);
        vt[13] = mk(-128, 3,  0, 0, 1, 127);

        repeat (3) @(negedge clk);
        chk("reset_state",  int'(state),  0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_lost",   int'(lost),   0);
        chk("reset_peak",   int'(peak),   0);
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < vt[i].reps; r++) apply(vt[i].err, vt[i].en);
            chk($sformatf("vec%0d_state", i),  int'(s_state),     int'(vt[i].st));
            chk($sformatf("vec%0d_locked", i), int'(s_locked),    int'(vt[i].lk));
            chk($sformatf("vec%0d_lost", i),   int'(s_lost),      int'(vt[i].lost));
            chk($sformatf("vec%0d_lost_1cyc", i), int'(s_lost_next), 0);
            chk($sformatf("vec%0d_peak", i),   int'(s_peak),      int'(vt[i].peak));
        end

        // Enable dropped together with the releasing strobe: no loss pulse.
        strobes(3, 64);
        chk("seq_en_lock", int'(s_state), 2);
        strobes(9, 3);
        chk("seq_en_hold", int'(s_state), 3);
        apply(9, 1'b0);
        chk("seq_en_state",  int'(s_state),     0);
        chk("seq_en_locked", int'(s_locked),    0);
        chk("seq_en_lost",   int'(s_lost),      0);
        chk("seq_en_lost2",  int'(s_lost_next), 0);
        enable = 1'b1;

        // Reset mid-acquire clears everything; acquisition restarts from zero.
        strobes(3, 10);
        chk("seq_rst_acq", int'(s_state), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("seq_rst_state",  int'(state),  0);
        chk("seq_rst_locked", int'(locked), 0);
        chk("seq_rst_lost",   int'(lost),   0);
        chk("seq_rst_peak",   int'(peak),   0);
        strobes(3, 63);
        chk("seq_rst_63", int'(s_state), 1);
        strobes(3, 1);
        chk("seq_rst_64", int'(s_state), 2);

        // ref_clk_i already high as reset releases produces an immediate strobe.
        @(negedge clk);
        reset   = 1'b1;
        ref_clk = 1'b1;
        err     = 8'sd3;
        @(negedge clk);
        @(negedge clk);
        chk("seq_refhi_in_reset", int'(state), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("seq_refhi_strobe", int'(state), 1);
        ref_clk = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adpll_lock_detect.md
# adpll_lock_detect

Lock detector placed directly downstream of the ring ADPLL in the 258 MHz domain. It samples the ADPLL's signed phase-error output once per reference-clock rising edge and qualifies lock with separate acquire and release thresholds and counts. It drives a registered lock flag for board LEDs and a loss-of-lock pulse, and optionally tracks peak error while locked.

## Interface
Parameters:
- ERR_WIDTH, 8: width of signed error input.
- LOCK_THRESH, 4: |error| ≤ this counts as a good sample for acquisition.
- UNLOCK_THRESH, 8: |error| > this counts as a bad sample while locked; must be ≥ LOCK_THRESH.
- LOCK_COUNT, 64: consecutive good samples needed to declare lock; range 1..2^CNT_WIDTH−1.
- UNLOCK_COUNT, 4: consecutive bad samples needed to drop lock; range 1..2^CNT_WIDTH−1.
- CNT_WIDTH, 8: width of the acquire and release counters.

Ports:
- fpga_clk_i  in  1  system clock (258 MHz); the only clock.
- reset_i  in  1  synchronous reset, active-high.
- enable_i  in  1  detector enable; low forces UNLOCKED.
- ref_clk_i  in  1  reference clock, generated in the fpga_clk_i domain. It is not synchronised here.
- error_i  in  ERR_WIDTH  signed ADPLL phase error, two's complement.
- locked_o  out  1  registered lock flag.
- lock_state_o  out  2  current state encoding.
- lost_lock_o  out  1  one-cycle pulse on the HOLDOVER→UNLOCKED transition.
- max_abs_error_o  out  ERR_WIDTH  peak |error| since the last LOCKED entry (see Configuration).

## Operation
- Strobe: ref_d is ref_clk_i registered. strobe = ref_clk_i & ~ref_d. error_i is sampled only in strobe cycles.
- Absolute value: abs_err = |error_i|, saturating, so the most-negative value (−128 at width 8) maps to 127. Comparisons are unsigned at ERR_WIDTH.
- States and encodings: UNLOCKED=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3. Transitions occur only on strobe cycles unless noted.
- UNLOCKED, good sample:
  - If LOCK_COUNT==1, go to LOCKED.
  - Otherwise go to ACQUIRE with acq_cnt=1.
- ACQUIRE:
  - Good sample: acq_cnt++. When the incremented value equals LOCK_COUNT, go to LOCKED.
  - Non-good sample: go to UNLOCKED with acq_cnt=0.
- LOCKED:
  - Bad sample: if UNLOCK_COUNT==1, go to UNLOCKED and pulse lost_lock_o. Otherwise go to HOLDOVER with rel_cnt=1.
  - Non-bad sample: no change.
- HOLDOVER:
  - Bad sample: rel_cnt++. When it reaches UNLOCK_COUNT, go to UNLOCKED, pulse lost_lock_o, and clear both counters.
  - Non-bad sample: return to LOCKED with rel_cnt=0.
- Samples with LOCK_THRESH < |err| ≤ UNLOCK_THRESH break acquisition but never count toward release (hysteresis band).
- locked_o is 1 in LOCKED and HOLDOVER.
- enable_i low (any cycle, with or without strobe): next state UNLOCKED, counters cleared, lost_lock_o not pulsed. Takes priority over the strobe.
- reset_i takes priority over everything:
  - state UNLOCKED, ref_d=0, counters=0;
  - locked_o=0, lock_state_o=0, lost_lock_o=0, max_abs_error_o=0.
- Counters never wrap; the terminal compare precedes any overflow.

## Timing
- All outputs are registered and update on the same fpga_clk_i edge as the state register.
- Latency: state, locked_o and lost_lock_o change on the clock edge that ends the strobe cycle. They are visible in the following cycle.
- A ref_clk_i already high when reset deasserts produces a strobe in the first cycle after reset, because ref_d resets to 0.
- lost_lock_o is high for exactly one cycle per release event.
- Reset mid-acquire or mid-holdover: counters are discarded and no pulse is generated.

## Configuration
- LOCK_PEAK_EN defined:
  - max_abs_error_o is cleared on the edge that enters LOCKED from ACQUIRE/UNLOCKED.
  - It updates to max(current, abs_err) on every strobe while in LOCKED or HOLDOVER.
  - It holds its value in other states.
- LOCK_PEAK_EN undefined: max_abs_error_o is tied to 0 and no peak register is synthesised.

## Structure
- Shared package adpll_pkg holds:
  - the lock_state_t 2-bit state typedef and its four encodings;
  - the ERR_WIDTH default constant shared with the ADPLL.
- Sub-module adpll_abs_sat computes the saturating absolute value. It is reused by display logic.
- The FSM and counters live in the top module.

## Test plan
- Reset then enable_i=1, error_i=3, strobe every 4 cycles (LOCK_COUNT=64) → locked_o rises one cycle after the 64th strobe edge; lock_state_o sequence 0→1→2.
- Locked, then error_i=9 for 3 strobes then 0 (UNLOCK_COUNT=4) → state 3 for 3 strobes, then back to 2; locked_o stays 1; no lost_lock_o.
- Locked, error_i=−20 for 4 strobes → state 0 after the 4th strobe; lost_lock_o=1 for exactly one cycle; locked_o=0.
- Acquiring at acq_cnt=63, error_i=6 (hysteresis band) → UNLOCKED, acq_cnt=0. With error_i=6 while LOCKED → stays LOCKED.
- error_i=−128 while locked with LOCK_PEAK_EN defined → max_abs_error_o=127. Release follows the bad-sample path.
- enable_i dropped in HOLDOVER coincident with the 4th bad strobe → state 0, lost_lock_o stays 0. A reset_i pulse mid-ACQUIRE zeroes all outputs.
